// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store initiator.
// Size codes, FSM states, lane masks and the alignment rule.
package mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam logic [31:0] LANE_B = 32'h0000_00FF;
  localparam logic [31:0] LANE_H = 32'h0000_FFFF;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_RSV
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  function automatic logic misaligned(
    input size_t      s,
    input logic [1:0] a
  );
    logic r;
    case (s)
      SZ_B:    r = 1'b0;
      SZ_H:    r = a[0];
      SZ_W:    r = (a != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane extraction, extension and store merge.
// Pure combinational; fed from the latched request only.
module mem_lane_align
  import mem_pkg::*;
(
  input  size_t       size_i,
  input  logic        uns_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ldata_o,
  output logic [31:0] sdata_o,
  output logic        mis_o
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [31:0] braw;
  logic [31:0] hraw;

  // select lane, extend for loads, splice lane for stores
  always_comb begin
    bsh     = {addr_i, 3'b000};
    hsh     = {addr_i[1], 4'b0000};
    braw    = (word_i >> bsh) & LANE_B;
    hraw    = (word_i >> hsh) & LANE_H;
    ldata_o = word_i;
    sdata_o = wdata_i;
    case (size_i)
      SZ_B: begin
        ldata_o = uns_i ? braw
                        : {{24{braw[7]}}, braw[7:0]};
        sdata_o = (word_i & ~(LANE_B << bsh))
                | ((wdata_i & LANE_B) << bsh);
      end
      SZ_H: begin
        ldata_o = uns_i ? hraw
                        : {{16{hraw[15]}}, hraw[15:0]};
        sdata_o = (word_i & ~(LANE_H << hsh))
                | ((wdata_i & LANE_H) << hsh);
      end
      default: ;
    endcase
    mis_o = misaligned(size_i, addr_i);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator: MEM stage to word-wide data memory.
// Sub-word stores are done as read-modify-write of a full word.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  localparam int OFF_W = $clog2(WORD_BYTES);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  size_t             size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       ldata;
  logic [31:0]       sdata;
  logic              mis;

  mem_lane_align u_align (
    .size_i  (size_q),
    .uns_i   (uns_q),
    .addr_i  (addr_q[1:0]),
    .word_i  (word_q),
    .wdata_i (wdata_q),
    .ldata_o (ldata),
    .sdata_o (sdata),
    .mis_o   (mis)
  );

  assign req_ready  = (state_q == IDLE) && reset_n;
  assign mem_a      = {addr_q[ADDR_W-1:OFF_W],
                       {OFF_W{1'b0}}};
  assign mem_we     = (state_q == WR);
  assign mem_wd     = mem_we ? sdata : '0;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && mis;
  assign resp_rdata = (resp_valid && !mis && !we_q)
                    ? ldata : '0;

  // next state, request latch and read capture
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          size_d  = size_t'(req_size);
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (misaligned(size_t'(req_size),
                         req_addr[1:0]))
            state_d = RESP;
          else if (req_we &&
                   size_t'(req_size) == SZ_W)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        word_d  = mem_rd;
        state_d = we_q ? WR : RESP;
      end
      WR:   state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and request registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a word memory model.
// Latencies, lane data, errors, backpressure and mid-op reset.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  int          lat, wcnt, wcyc;
  logic [31:0] rd, wd;
  logic        er;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_a        (mem_a),
    .mem_we       (mem_we),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  assign mem_rd = mem[mem_a[9:2]];

  always @(posedge clk)
    if (mem_we) mem[mem_a[9:2]] <= mem_wd;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic we,
                       input logic [1:0] sz,
                       input logic uns,
                       input logic [31:0] a,
                       input logic [31:0] wdat);
    @(negedge clk);
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wdat;
    req_valid    = 1'b1;
    chk("req_ready_idle", {31'b0, req_ready}, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(input bit ack,
                           output int l,
                           output logic [31:0] r,
                           output logic e,
                           output int wc,
                           output int wy,
                           output logic [31:0] w);
    l  = 0;
    wc = 0;
    wy = 0;
    w  = '0;
    r  = '0;
    e  = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_we) begin
        wc++;
        wy = c;
        w  = mem_wd;
      end
      if (resp_valid) begin
        l = c;
        r = resp_rdata;
        e = resp_err;
        break;
      end
    end
    if (l == 0) chk("resp_timeout", 0, 1);
    else if (ack) begin
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
    end
  endtask

  task automatic run_load(input string tag,
                          input logic [1:0] sz,
                          input logic uns,
                          input logic [31:0] a,
                          input logic [31:0] exp);
    issue(1'b0, sz, uns, a, 32'h0);
    wait_resp(1'b1, lat, rd, er, wcnt, wcyc, wd);
    chk({tag, "_lat"}, 32'(lat), 2);
    chk({tag, "_rdata"}, rd, exp);
    chk({tag, "_err"}, {31'b0, er}, 0);
    chk({tag, "_nowe"}, 32'(wcnt), 0);
  endtask

  task automatic run_err(input string tag,
                         input logic we,
                         input logic [1:0] sz,
                         input logic [31:0] a);
    issue(we, sz, 1'b0, a, 32'hFFFF_FFFF);
    wait_resp(1'b1, lat, rd, er, wcnt, wcyc, wd);
    chk({tag, "_lat"}, 32'(lat), 1);
    chk({tag, "_err"}, {31'b0, er}, 1);
    chk({tag, "_rdata"}, rd, 0);
    chk({tag, "_nowe"}, 32'(wcnt), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'h8BAD_F00D;
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    resp_ready   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_resp_err", {31'b0, resp_err}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wd", mem_wd, 0);
    chk("rst_req_ready", {31'b0, req_ready}, 0);
    reset_n = 1'b1;

    run_load("lb101", 2'b00, 1'b0, 32'h101, 32'hFFFF_FFF0);
    run_load("lbu101", 2'b00, 1'b1, 32'h101, 32'h0000_00F0);
    run_load("lh102", 2'b01, 1'b0, 32'h102, 32'hFFFF_8BAD);
    run_load("lhu102", 2'b01, 1'b1, 32'h102, 32'h0000_8BAD);
    run_load("lw100", 2'b10, 1'b0, 32'h100, 32'h8BAD_F00D);

    issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_0055);
    wait_resp(1'b1, lat, rd, er, wcnt, wcyc, wd);
    chk("sb_lat", 32'(lat), 3);
    chk("sb_wecnt", 32'(wcnt), 1);
    chk("sb_wecyc", 32'(wcyc), 2);
    chk("sb_wd", wd, 32'h55AD_F00D);
    chk("sb_rdata", rd, 0);
    chk("sb_mem", mem[8'h40], 32'h55AD_F00D);

    issue(1'b1, 2'b10, 1'b0, 32'h104, 32'h1234_5678);
    wait_resp(1'b1, lat, rd, er, wcnt, wcyc, wd);
    chk("sw_lat", 32'(lat), 2);
    chk("sw_wecyc", 32'(wcyc), 1);
    chk("sw_wd", wd, 32'h1234_5678);

    issue(1'b1, 2'b01, 1'b0, 32'h106, 32'hFFFF_BEEF);
    wait_resp(1'b1, lat, rd, er, wcnt, wcyc, wd);
    chk("sh_lat", 32'(lat), 3);
    chk("sh_mem", mem[8'h41], 32'hBEEF_5678);

    run_err("lh101", 1'b0, 2'b01, 32'h101);
    run_err("lw102", 1'b0, 2'b10, 32'h102);
    run_err("rsv", 1'b0, 2'b11, 32'h100);
    run_err("sh101", 1'b1, 2'b01, 32'h101);
    chk("err_mem40", mem[8'h40], 32'h55AD_F00D);
    chk("err_mem41", mem[8'h41], 32'hBEEF_5678);

    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    wait_resp(1'b0, lat, rd, er, wcnt, wcyc, wd);
    chk("bp_lat", 32'(lat), 2);
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h104;
    req_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, resp_valid}, 1);
      chk("bp_rdata", resp_rdata, 32'h55AD_F00D);
      chk("bp_ready", {31'b0, req_ready}, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_ready", {31'b0, req_ready}, 1);
    chk("bp_idle_valid", {31'b0, resp_valid}, 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(1'b1, lat, rd, er, wcnt, wcyc, wd);
    chk("bp_next_lat", 32'(lat), 2);
    chk("bp_next_rdata", rd, 32'h0000_0078);

    issue(1'b1, 2'b10, 1'b0, 32'h108, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rw_we_high", {31'b0, mem_we}, 1);
    reset_n = 1'b0;
    #1;
    chk("rw_we_drop", {31'b0, mem_we}, 0);
    chk("rw_wd", mem_wd, 0);
    chk("rw_mem_a", mem_a, 0);
    chk("rw_valid", {31'b0, resp_valid}, 0);
    chk("rw_ready", {31'b0, req_ready}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rw_mem", mem[8'h42], 32'h0);
    reset_n = 1'b1;
    run_load("lw108", 2'b10, 1'b0, 32'h108, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
